spi_input_conditioner: RTL

- Parametrised front end for SPI target logic: synchronises SCK, CS_N and N data lanes into the `clk` domain and deglitches them.
- Also decodes SPI mode (CPOL/CPHA) into single-cycle sample/shift strobes and chip-select framing pulses.
- Sits between the package pins and the SPI shift/command logic.
- Replaces the bare two-flop synchroniser with configurable depth, lane count, filtering and edge decoding.

---
 rtl/spi_input_conditioner.sv | 131 +++++++++++++
 1 files changed

// File: rtl/spi_input_conditioner.sv
// SPI pin front end: synchronises and deglitches SCK, CS_N and data lanes,
// then decodes mode-dependent sample/shift strobes and chip-select framing.
module spi_input_conditioner #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 2,
    parameter int   NUM_DATA    = 1,
    parameter logic CPOL        = 1'b0,
    parameter logic CPHA        = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sck,
    input  logic                cs_n,
    input  logic [NUM_DATA-1:0] sdi,
    output logic                sck_out,
    output logic                cs_n_out,
    output logic [NUM_DATA-1:0] sdi_out,
    output logic                sample_strobe,
    output logic                shift_strobe,
    output logic [NUM_DATA-1:0] sample_data,
    output logic                cs_start,
    output logic                cs_end
);

    localparam int NSIG = NUM_DATA + 2;
    localparam int CW   = $clog2(FILTER_LEN) + 1;

    // Bit 0 is SCK, bit 1 is CS_N, the rest are the data lanes.
    localparam logic [NSIG-1:0] RST_VAL = {{NUM_DATA{1'b0}}, 1'b1, CPOL};

    logic [NSIG-1:0]     w_raw;
    logic [NSIG-1:0]     w_filt;
    logic                w_sck_f;
    logic                w_cs_f;
    logic [NUM_DATA-1:0] w_sdi_f;
    logic                w_sck_edge;
    logic                w_lead;
    logic                w_trail;
    logic                w_samp;
    logic                w_shift;

    logic                r_sck_prev;
    logic                r_cs_prev;
    logic                r_sample_strobe;
    logic                r_shift_strobe;
    logic [NUM_DATA-1:0] r_sample_data;
    logic                r_cs_start;
    logic                r_cs_end;

    assign w_raw = {sdi, cs_n, sck};

    genvar g;
    generate
        for (g = 0; g < NSIG; g++) begin : g_sig
            logic [SYNC_STAGES-1:0] r_sync;
            logic [CW-1:0]          r_cnt;
            logic                   r_filt;
            logic                   w_synced;

            assign w_synced = r_sync[SYNC_STAGES-1];
            assign w_filt[g] = r_filt;

            // Metastability chain: shift the raw pin in at the LSB.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync <= {SYNC_STAGES{RST_VAL[g]}};
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
                end
            end

            // Deglitch: adopt the synced value only after a run of disagreeing samples.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt  <= '0;
                    r_filt <= RST_VAL[g];
                end else if (w_synced == r_filt) begin
                    r_cnt <= '0;
                end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                    r_filt <= w_synced;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    endgenerate

    assign w_sck_f = w_filt[0];
    assign w_cs_f  = w_filt[1];
    assign w_sdi_f = w_filt[NSIG-1:2];

    assign w_sck_edge = (w_sck_f != r_sck_prev);
    assign w_lead     = w_sck_edge & (w_sck_f != CPOL);
    assign w_trail    = w_sck_edge & (w_sck_f == CPOL);
    assign w_samp     = CPHA ? w_trail : w_lead;
    assign w_shift    = CPHA ? w_lead : w_trail;

    // Edge decode: registered strobes, data capture and CS framing pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_prev      <= CPOL;
            r_cs_prev       <= 1'b1;
            r_sample_strobe <= 1'b0;
            r_shift_strobe  <= 1'b0;
            r_sample_data   <= '0;
            r_cs_start      <= 1'b0;
            r_cs_end        <= 1'b0;
        end else begin
            r_sck_prev      <= w_sck_f;
            r_cs_prev       <= w_cs_f;
            r_sample_strobe <= w_samp & ~w_cs_f;
            r_shift_strobe  <= w_shift & ~w_cs_f;
            if (w_samp & ~w_cs_f) begin
                r_sample_data <= w_sdi_f;
            end
            r_cs_start <= r_cs_prev & ~w_cs_f;
            r_cs_end   <= ~r_cs_prev & w_cs_f;
        end
    end

    assign sck_out       = w_sck_f;
    assign cs_n_out      = w_cs_f;
    assign sdi_out       = w_sdi_f;
    assign sample_strobe = r_sample_strobe;
    assign shift_strobe  = r_shift_strobe;
    assign sample_data   = r_sample_data;
    assign cs_start      = r_cs_start;
    assign cs_end        = r_cs_end;

endmodule
